// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding a single 8N1 UART transmitter.
// Optional line lock (whole lines stay together): define UART_TX_ARB_LINE_LOCK_EN.
module uart_tx_arbiter #(
    parameter  int NUM_REQ = 2,
    parameter  int CLK_DIV = 868,
    localparam int GID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx,
    output logic                 busy,
    output logic [GID_W-1:0]     grant_id
);

    localparam int               TMR_W    = $clog2(CLK_DIV);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state_reg, state_next;
    logic [TMR_W-1:0]   timer_reg, timer_next;
    logic [2:0]         bit_reg, bit_next;
    logic [7:0]         shift_reg, shift_next;
    logic               tx_reg, tx_next;
    logic               busy_reg, busy_next;
    logic [GID_W-1:0]   last_reg, last_next;
    logic [GID_W-1:0]   grant_reg, grant_next;

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] scan;
    logic [GID_W-1:0]   winner;
    logic               found;
    logic               handshake;
    logic               timer_done;
    logic [7:0]         win_data;

`ifdef UART_TX_ARB_LINE_LOCK_EN
    logic               lock_reg, lock_next;
    logic [GID_W-1:0]   lock_id_reg, lock_id_next;

    // While a line is open only its owner may be granted.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_elig
            assign eligible[gi] = req_valid[gi] && (!lock_reg || (lock_id_reg == GID_W'(gi)));
        end
    endgenerate
`else
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_elig
            assign eligible[gi] = req_valid[gi];
        end
    endgenerate
`endif

    // Search starts just after the last winner and wraps around.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        scan   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan = eligible >> ((int'(last_reg) + k) % NUM_REQ);
            if (!found && scan[0]) begin
                found  = 1'b1;
                winner = GID_W'((int'(last_reg) + k) % NUM_REQ);
            end
        end
    end

    assign req_ready  = (state_reg == IDLE && found && !reset) ? (NUM_REQ'(1) << winner) : '0;
    assign handshake  = |req_ready;
    assign win_data   = 8'(req_data >> {winner, 3'b000});
    assign timer_done = (timer_reg == TMR_LAST);

    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        tx_next    = tx_reg;
        busy_next  = busy_reg;
        last_next  = last_reg;
        grant_next = grant_reg;
`ifdef UART_TX_ARB_LINE_LOCK_EN
        lock_next    = lock_reg;
        lock_id_next = lock_id_reg;
`endif
        case (state_reg)
            IDLE: begin
                tx_next   = 1'b1;
                busy_next = 1'b0;
                if (handshake) begin
                    shift_next = win_data;
                    last_next  = winner;
                    grant_next = winner;
                    timer_next = '0;
                    tx_next    = 1'b0;
                    busy_next  = 1'b1;
                    state_next = START;
`ifdef UART_TX_ARB_LINE_LOCK_EN
                    if (win_data != 8'h0A) begin
                        lock_next    = 1'b1;
                        lock_id_next = winner;
                    end else if (winner == lock_id_reg) begin
                        lock_next = 1'b0;
                    end
`endif
                end
            end
            START: begin
                if (timer_done) begin
                    timer_next = '0;
                    bit_next   = 3'd0;
                    tx_next    = shift_reg[0];
                    shift_next = shift_reg >> 1;
                    state_next = DATA;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            DATA: begin
                if (timer_done) begin
                    timer_next = '0;
                    if (bit_reg == 3'd7) begin
                        tx_next    = 1'b1;
                        state_next = STOP;
                    end else begin
                        bit_next   = bit_reg + 3'd1;
                        tx_next    = shift_reg[0];
                        shift_next = shift_reg >> 1;
                    end
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            STOP: begin
                if (timer_done) begin
                    timer_next = '0;
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
            timer_reg <= '0;
            bit_reg   <= 3'd0;
            shift_reg <= 8'd0;
            tx_reg    <= 1'b1;
            busy_reg  <= 1'b0;
            last_reg  <= GID_W'(NUM_REQ - 1);
            grant_reg <= '0;
`ifdef UART_TX_ARB_LINE_LOCK_EN
            lock_reg    <= 1'b0;
            lock_id_reg <= '0;
`endif
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            tx_reg    <= tx_next;
            busy_reg  <= busy_next;
            last_reg  <= last_next;
            grant_reg <= grant_next;
`ifdef UART_TX_ARB_LINE_LOCK_EN
            lock_reg    <= lock_next;
            lock_id_reg <= lock_id_next;
`endif
        end
    end

    assign tx       = tx_reg;
    assign busy     = busy_reg;
    assign grant_id = grant_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: arbitration table, directed frame sequences,
// and random traffic checked cycle-by-cycle against a frame-level reference model.
module tb_uart_tx_arbiter;

    localparam int N     = 2;
    localparam int DIV   = 4;
    localparam int FRAME = 10 * DIV;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [N-1:0]     req_valid = '0;
    logic [N*8-1:0]   req_data = '0;
    logic [N-1:0]     req_ready;
    logic             tx;
    logic             busy;
    logic [0:0]       grant_id;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    uart_tx_arbiter #(.NUM_REQ(N), .CLK_DIV(DIV)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx        (tx),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    // Reference model: a frame is a 10-bit pattern held DIV cycles per bit,
    // grants follow the round-robin / line-lock rules on the current request set.
    int          m_ph      = -1;
    int          m_last    = N - 1;
    int          m_grant   = 0;
    bit          m_lock    = 1'b0;
    int          m_lock_id = 0;
    logic [9:0]  m_frame   = 10'h3FF;

    function automatic logic [N-1:0] pick(input logic [N-1:0] v);
        logic [N-1:0] oh;
        oh = '0;
        for (int k = 1; k <= N; k++) begin
            int i = (m_last + k) % N;
            if (v[i] && (!m_lock || i == m_lock_id)) begin
                oh[i] = 1'b1;
                return oh;
            end
        end
        return oh;
    endfunction

    always @(negedge clock) begin : model
        logic         exp_tx;
        logic         exp_busy;
        logic [N-1:0] exp_ready;
        logic [7:0]   b;
        int           w;
        cyc++;
        if (m_ph >= 0) begin
            exp_tx    = m_frame[m_ph / DIV];
            exp_busy  = 1'b1;
            exp_ready = '0;
        end else begin
            exp_tx    = 1'b1;
            exp_busy  = 1'b0;
            exp_ready = reset ? '0 : pick(req_valid);
        end
        check("model_tx", 32'(tx), 32'(exp_tx));
        check("model_busy", 32'(busy), 32'(exp_busy));
        check("model_ready", 32'(req_ready), 32'(exp_ready));
        check("model_grant", 32'(grant_id), 32'(m_grant));
        if (reset) begin
            m_ph    = -1;
            m_last  = N - 1;
            m_grant = 0;
            m_lock  = 1'b0;
        end else if (m_ph >= 0) begin
            m_ph++;
            if (m_ph == FRAME) m_ph = -1;
        end else if (exp_ready != '0) begin
            w = 0;
            for (int i = 0; i < N; i++) if (exp_ready[i]) w = i;
            b       = req_data[w*8 +: 8];
            m_frame = {1'b1, b, 1'b0};
            m_last  = w;
            m_grant = w;
            m_ph    = 0;
`ifdef UART_TX_ARB_LINE_LOCK_EN
            if (b != 8'h0A) begin
                m_lock    = 1'b1;
                m_lock_id = w;
            end else begin
                m_lock = 1'b0;
            end
`endif
        end
    end

    // Independent serial decoder: samples mid-bit, drops frames cut by reset.
    logic [7:0] rx_q[$];
    bit         rx_act  = 1'b0;
    int         rx_cnt  = 0;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_prev = 1'b1;

    always @(negedge clock) begin : decoder
        int k;
        if (reset) begin
            rx_act  = 1'b0;
            rx_prev = 1'b1;
        end else begin
            if (!rx_act) begin
                if (rx_prev === 1'b1 && tx === 1'b0) begin
                    rx_act = 1'b1;
                    rx_cnt = 0;
                end
            end else begin
                rx_cnt++;
            end
            if (rx_act && rx_cnt >= DIV && (rx_cnt % DIV) == DIV / 2) begin
                k = rx_cnt / DIV - 1;
                if (k < 8) begin
                    rx_byte[k] = tx;
                end else begin
                    if (tx === 1'b1) rx_q.push_back(rx_byte);
                    rx_act = 1'b0;
                end
            end
            rx_prev = tx;
        end
    end

    typedef struct {
        logic [N-1:0]   valid;
        logic [N*8-1:0] data;
        logic [N-1:0]   exp_ready;
    } vec_t;

    vec_t       tbl[4];
    logic [7:0] dq[N][$];
    int         grants[$];
    logic [7:0] exp_b[$];
    int         exp_g[$];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        reset     = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        rx_q.delete();
        grants.delete();
    endtask

    // Presents queued bytes per requester until all are accepted.
    task automatic drive_queues(input string tag);
        logic [N-1:0] hs;
        int left;
        left = 1000;
        forever begin
            for (int i = 0; i < N; i++) begin
                req_valid[i] = (dq[i].size() > 0);
                if (dq[i].size() > 0) req_data[i*8 +: 8] = dq[i][0];
            end
            if (req_valid == '0) break;
            if (left == 0) begin
                checks++;
                failures++;
                $display("FAIL %s_timeout got=no_handshake exp=handshake", tag);
                break;
            end
            left--;
            #1;
            hs = req_valid & req_ready;
            tick();
            for (int i = 0; i < N; i++) begin
                if (hs[i]) begin
                    void'(dq[i].pop_front());
                    grants.push_back(int'(grant_id));
                end
            end
        end
        req_valid = '0;
    endtask

    task automatic wait_rx(input int n, input string tag);
        int left;
        left = 2000;
        while (rx_q.size() < n && left > 0) begin
            tick();
            left--;
        end
        check({tag, "_rx_count"}, 32'(rx_q.size()), 32'(n));
    endtask

    task automatic check_bytes(input string tag);
        for (int i = 0; i < exp_b.size(); i++)
            check({tag, "_byte"}, (i < rx_q.size()) ? 32'(rx_q[i]) : 32'h100, 32'(exp_b[i]));
    endtask

    task automatic check_grants(input string tag);
        for (int i = 0; i < exp_g.size(); i++)
            check({tag, "_grant"}, (i < grants.size()) ? 32'(grants[i]) : 32'hFF, 32'(exp_g[i]));
    endtask

    initial begin
        logic [N-1:0] hs;
        logic [9:0]   sb_pat;

        tbl[0] = '{valid: 2'b00, data: 16'h0000, exp_ready: 2'b00};
        tbl[1] = '{valid: 2'b01, data: 16'h0011, exp_ready: 2'b01};
        tbl[2] = '{valid: 2'b10, data: 16'h2200, exp_ready: 2'b10};
        tbl[3] = '{valid: 2'b11, data: 16'h3344, exp_ready: 2'b01};

        // Reset state
        repeat (3) tick();
        check("rst_tx", 32'(tx), 32'h1);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_grant", 32'(grant_id), 32'h0);
        req_valid = 2'b11;
        #1;
        check("rst_ready", 32'(req_ready), 32'h0);
        req_valid = '0;
        tick();
        reset = 1'b0;
        tick();

        // Arbitration table from reset (requester 0 first); valid withdrawn before the edge
        for (int t = 0; t < 4; t++) begin
            req_valid = tbl[t].valid;
            req_data  = tbl[t].data;
            #1;
            check("tbl_ready", 32'(req_ready), 32'(tbl[t].exp_ready));
            req_valid = '0;
            tick();
        end

        // Single byte 0x55: exact line pattern, ready held off for the whole frame
        do_reset();
        sb_pat = 10'b1010101010;
        req_data[7:0] = 8'h55;
        req_valid     = 2'b01;
        #1;
        check("sb_ready_first", 32'(req_ready), 32'h1);
        tick();
        req_data[7:0] = 8'hA5;
        for (int j = 1; j <= FRAME; j++) begin
            check("sb_tx", 32'(tx), 32'(sb_pat[(j-1)/DIV]));
            check("sb_busy", 32'(busy), 32'h1);
            check("sb_ready_held", 32'(req_ready), 32'h0);
            tick();
        end
        check("sb_busy_end", 32'(busy), 32'h0);
        check("sb_ready_next", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        wait_rx(2, "sb");
        exp_b = '{8'h55, 8'hA5};
        check_bytes("sb");

        // Fairness: both requesters always valid
        do_reset();
        dq[0] = '{8'h41, 8'h41};
        dq[1] = '{8'h42, 8'h42};
        drive_queues("fair");
        wait_rx(4, "fair");
        exp_b = '{8'h41, 8'h42, 8'h41, 8'h42};
        exp_g = '{0, 1, 0, 1};
        check_bytes("fair");
        check_grants("fair");

        // Line lock: req0 streams "A\n", req1 holds "B" from the start
        do_reset();
        dq[0] = '{8'h41, 8'h0A};
        dq[1] = '{8'h42};
        drive_queues("lock");
        wait_rx(3, "lock");
`ifdef UART_TX_ARB_LINE_LOCK_EN
        exp_b = '{8'h41, 8'h0A, 8'h42};
        exp_g = '{0, 0, 1};
`else
        exp_b = '{8'h41, 8'h42, 8'h0A};
        exp_g = '{0, 1, 0};
`endif
        check_bytes("lock");
        check_grants("lock");

        // Reset during DATA bit 3 of req0's frame; req0 must still win first afterwards
        do_reset();
        req_data  = {8'h99, 8'h3C};
        req_valid = 2'b01;
        tick();
        req_valid = 2'b10;
        repeat (16) tick();
        check("rm_bit3", 32'(tx), 32'h1);
        reset = 1'b1;
        tick();
        check("rm_tx", 32'(tx), 32'h1);
        check("rm_busy", 32'(busy), 32'h0);
        check("rm_ready", 32'(req_ready), 32'h0);
        reset     = 1'b0;
        rx_q.delete();
        grants.delete();
        req_data  = {8'h99, 8'h5A};
        req_valid = 2'b11;
        #1;
        check("rm_first_ready", 32'(req_ready), 32'h1);
        dq[0] = '{8'h5A};
        dq[1] = '{8'h99};
        drive_queues("rm");
        wait_rx(2, "rm");
        exp_b = '{8'h5A, 8'h99};
        exp_g = '{0, 1};
        check_bytes("rm");
        check_grants("rm");

        // Withdraw: req1 valid only while req0's frame is in flight
        do_reset();
        req_data[7:0] = 8'hC3;
        req_valid     = 2'b01;
        tick();
        req_valid = 2'b00;
        repeat (10) tick();
        req_data[15:8] = 8'h77;
        req_valid      = 2'b10;
        repeat (20) tick();
        req_valid = 2'b00;
        repeat (15) tick();
        check("wd_tx", 32'(tx), 32'h1);
        check("wd_busy", 32'(busy), 32'h0);
        check("wd_grant", 32'(grant_id), 32'h0);
        check("wd_rx_count", 32'(rx_q.size()), 32'h1);
        exp_b = '{8'hC3};
        check_bytes("wd");

        // Random traffic with withdrawals; the model checks every cycle
        do_reset();
        hs = '0;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (hs[i] || !req_valid[i]) begin
                    req_valid[i] = ($urandom_range(0, 3) != 0);
                    req_data[i*8 +: 8] = ($urandom_range(0, 2) == 0) ? 8'h0A : 8'($urandom);
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            #1;
            hs = req_valid & req_ready;
            tick();
        end
        req_valid = '0;
        repeat (FRAME + 5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART transmit line among several on-chip byte producers, such as the boot console, the trace/commit checker, and the failure reporter. Requesters are served round-robin, and each accepted byte is serialised as 8N1 at a fixed clock divider. The block's `tx` output drives the SoC `io_uart_tx` pin, so it sits directly upstream of the harness-side tty monitor. All sequencing is internal: one byte in flight, one grant at a time.

## Interface
- `NUM_REQ`, default 2: number of requesters, range 1..8.
- `CLK_DIV`, default 868: clocks per bit, minimum 2. The default is 115200 baud at 100 MHz.
- `clock` input, 1: sole clock, rising edge.
- `reset` input, 1: synchronous, active-high.
- `req_valid` input, `NUM_REQ`: requester i holds a byte.
- `req_data` input, `NUM_REQ*8`: byte of requester i, in bits [8i+7:8i].
- `req_ready` output, `NUM_REQ`: one-hot or zero. Byte i is accepted on a cycle where `req_valid[i] && req_ready[i]`.
- `tx` output, 1: serial line, idle high.
- `busy` output, 1: a frame is being transmitted.
- `grant_id` output, `$clog2(NUM_REQ)` (min 1): index of the last accepted requester.

## Operation
- State machine IDLE → START → DATA → STOP → IDLE.
- **IDLE**
  - `tx`=1, `busy`=0.
  - Arbiter picks the first requester with `req_valid` set, searching from `last+1` upward with wrap-around modulo `NUM_REQ`.
  - `req_ready` is asserted combinationally to that winner only.
  - On handshake: latch the byte, set `last` and `grant_id` to the winner, go to START.
- **START**: `tx`=0 for `CLK_DIV` cycles.
- **DATA**: 8 bits, LSB first, each held `CLK_DIV` cycles. A 3-bit index counts 0..7.
- **STOP**: `tx`=1 for `CLK_DIV` cycles, then IDLE.
- **Counters**
  - Bit timer has width `$clog2(CLK_DIV)`. It counts 0..`CLK_DIV`-1, and the state or bit advances when it reaches `CLK_DIV`-1.
  - The timer is cleared on every state entry.
- `req_ready` is 0 in every state other than IDLE. A requester dropping `req_valid` without a handshake is legal; nothing is latched.
- `req_data` is sampled only on the handshake cycle.
- **Reset values**: `tx`=1, `busy`=0, `req_ready`=0, `grant_id`=0, `last`=`NUM_REQ`-1 (so requester 0 wins first), lock clear, state IDLE.
- **Reset mid-frame**: the next edge returns to IDLE with `tx`=1. The partial byte is discarded and never retransmitted.
- **`NUM_REQ`=1**: degenerates to a plain transmitter; `grant_id` is constantly 0.

## Timing
- Handshake at edge T (cycle T):
  - `tx` falls and `busy` rises after edge T. Frame bits occupy cycles T+1 .. T+10·`CLK_DIV`.
  - State is IDLE again in cycle T+10·`CLK_DIV`+1, and a new handshake may occur in that same cycle.
- Byte-to-byte period under continuous demand is 10·`CLK_DIV`+1 cycles.
- Arbitration latency from `req_valid` to `req_ready` is zero cycles if IDLE. Otherwise `req_ready` waits until the return to IDLE.
- `tx` and `busy` are registered outputs; `req_ready` is combinational from state, lock and `req_valid`.

## Configuration
- Macro: `UART_TX_ARB_LINE_LOCK_EN`.
- **Defined**
  - A handshake carrying a byte other than 0x0A sets `lock` and records `lock_id`=winner.
  - While `lock` is set, only `lock_id` is eligible in IDLE; other `req_valid` bits wait.
  - A handshake carrying 0x0A from `lock_id` clears the lock. Round-robin then resumes from `lock_id`+1.
  - Whole lines are never interleaved.
  - Reset clears the lock.
- **Undefined**: no lock state exists, and arbitration is strictly per byte.

## Test plan
- **Single byte**: `CLK_DIV`=4, req0 sends 0x55.
  - `req_ready[0]` pulses 1 cycle.
  - `tx` is 0,1,0,1,0,1,0,1,0,1 with 4 cycles per bit.
  - `busy` is high for 40 cycles, and next ready comes 41 cycles after the handshake.
- **Fairness**: `CLK_DIV`=4, req0 and req1 both continuously valid with 0x41 and 0x42.
  - Serial order is 0x41, 0x42, 0x41, 0x42.
  - `grant_id` sequence is 0,1,0,1.
- **Line lock, macro defined**: req0 streams "A","\n" and req1 holds "B" valid from cycle 0.
  - Order is 0x41, 0x0A, 0x42.
- **Line lock, macro undefined**: same stimulus.
  - Order is 0x41, 0x42, 0x0A.
- **Reset mid-frame**: `reset` is asserted 1 cycle during DATA bit 3.
  - Next cycle: `tx`=1, `busy`=0, `req_ready`=0.
  - After deassert, req0 is granted first even if req1 was `last`.
- **Requester withdraw**: req1 raises `req_valid` during a frame and drops it before IDLE.
  - No handshake for req1.
  - `tx` stays high after STOP.
